// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register plus data-cache access controller.
// Loads/stores stall the pipeline until the cache answers; halfword data is formatted here.
module ex_mem_stage #(
  parameter int pc_size   = 18,
  parameter int data_size = 32,
  parameter int addr_size = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EX_MemtoReg,
  input  logic                 EX_RegWrite,
  input  logic                 EX_MemWrite,
  input  logic                 EX_Jal,
  input  logic                 EX_ExtendLH,
  input  logic                 EX_ExtendSH,
  input  logic [pc_size-1:0]   EX_PC,
  input  logic [data_size-1:0] EX_ALU_result,
  input  logic [data_size-1:0] EX_Rt_data,
  input  logic [4:0]           EX_WR_out,
  input  logic                 DM_ready,
  input  logic [data_size-1:0] DM_rdata,
  output logic                 DM_req,
  output logic                 DM_we,
  output logic [addr_size-1:0] DM_addr,
  output logic [data_size-1:0] DM_wdata,
  output logic [3:0]           DM_be,
  output logic                 M_Stall,
  output logic                 M_MemtoReg,
  output logic                 M_RegWrite,
  output logic                 M_Jal,
  output logic [pc_size-1:0]   M_PC,
  output logic [data_size-1:0] M_ALU_result,
  output logic [4:0]           M_WR_out,
  output logic [data_size-1:0] M_MemData
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 memto_reg_q, memto_reg_d;
  logic                 reg_write_q, reg_write_d;
  logic                 mem_write_q, mem_write_d;
  logic                 jal_q, jal_d;
  logic                 extend_lh_q, extend_lh_d;
  logic                 extend_sh_q, extend_sh_d;
  logic [pc_size-1:0]   pc_q, pc_d;
  logic [data_size-1:0] alu_result_q, alu_result_d;
  logic [data_size-1:0] rt_data_q, rt_data_d;
  logic [4:0]           wr_out_q, wr_out_d;
  logic [data_size-1:0] mem_data_q, mem_data_d;

  logic                 mem_op;
  logic                 access;
  logic                 stall;
  logic                 load_done;
  logic [15:0]          load_half;
  logic [data_size-1:0] load_fmt;

  assign mem_op    = memto_reg_q | mem_write_q;
  assign access    = (state_q == ACCESS);
  assign stall     = ((state_q == IDLE) && mem_op) || access;
  assign load_done = access && DM_ready && memto_reg_q;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = ACCESS;
      ACCESS:  if (DM_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    memto_reg_d  = memto_reg_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    jal_d        = jal_q;
    extend_lh_d  = extend_lh_q;
    extend_sh_d  = extend_sh_q;
    pc_d         = pc_q;
    alu_result_d = alu_result_q;
    rt_data_d    = rt_data_q;
    wr_out_d     = wr_out_q;
    if (!stall) begin
      memto_reg_d  = EX_MemtoReg;
      reg_write_d  = EX_RegWrite;
      mem_write_d  = EX_MemWrite;
      jal_d        = EX_Jal;
      extend_lh_d  = EX_ExtendLH;
      extend_sh_d  = EX_ExtendSH;
      pc_d         = EX_PC;
      alu_result_d = EX_ALU_result;
      rt_data_d    = EX_Rt_data;
      wr_out_d     = EX_WR_out;
    end
  end

  // Halfword loads pick the half addressed by bit 1; bit 0 is ignored.
  always_comb begin
    load_half = alu_result_q[1] ? DM_rdata[31:16] : DM_rdata[15:0];
    load_fmt  = DM_rdata;
    if (extend_lh_q) load_fmt = {{(data_size-16){load_half[15]}}, load_half};
    mem_data_d = load_done ? load_fmt : mem_data_q;
  end

  always_comb begin
    DM_wdata = '0;
    DM_be    = 4'b0000;
    if (access) begin
      DM_wdata = rt_data_q;
      DM_be    = 4'b1111;
      if (mem_write_q && extend_sh_q) begin
        DM_wdata = {(data_size/16){rt_data_q[15:0]}};
        DM_be    = alu_result_q[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  assign DM_req  = access;
  assign DM_we   = access & mem_write_q;
  assign DM_addr = alu_result_q[addr_size+1:2];
  assign M_Stall = stall;

  assign M_MemtoReg   = memto_reg_q;
  assign M_RegWrite   = reg_write_q;
  assign M_Jal        = jal_q;
  assign M_PC         = pc_q;
  assign M_ALU_result = alu_result_q;
  assign M_WR_out     = wr_out_q;
  assign M_MemData    = mem_data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      memto_reg_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      jal_q        <= 1'b0;
      extend_lh_q  <= 1'b0;
      extend_sh_q  <= 1'b0;
      pc_q         <= '0;
      alu_result_q <= '0;
      rt_data_q    <= '0;
      wr_out_q     <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      memto_reg_q  <= memto_reg_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      jal_q        <= jal_d;
      extend_lh_q  <= extend_lh_d;
      extend_sh_q  <= extend_sh_d;
      pc_q         <= pc_d;
      alu_result_q <= alu_result_d;
      rt_data_q    <= rt_data_d;
      wr_out_q     <= wr_out_d;
      mem_data_q   <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a driver queues expected commits and cache requests,
// a cache responder answers with programmed latency, and a monitor compares at negedge.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic        EX_MemtoReg, EX_RegWrite, EX_MemWrite, EX_Jal, EX_ExtendLH, EX_ExtendSH;
  logic [17:0] EX_PC;
  logic [31:0] EX_ALU_result, EX_Rt_data;
  logic [4:0]  EX_WR_out;
  logic        DM_ready;
  logic [31:0] DM_rdata;
  logic        DM_req, DM_we;
  logic [15:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [3:0]  DM_be;
  logic        M_Stall, M_MemtoReg, M_RegWrite, M_Jal;
  logic [17:0] M_PC;
  logic [31:0] M_ALU_result;
  logic [4:0]  M_WR_out;
  logic [31:0] M_MemData;

  ex_mem_stage #(.pc_size(18), .data_size(32), .addr_size(16)) dut (
    .clk(clk), .rst(rst),
    .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite), .EX_MemWrite(EX_MemWrite),
    .EX_Jal(EX_Jal), .EX_ExtendLH(EX_ExtendLH), .EX_ExtendSH(EX_ExtendSH),
    .EX_PC(EX_PC), .EX_ALU_result(EX_ALU_result), .EX_Rt_data(EX_Rt_data), .EX_WR_out(EX_WR_out),
    .DM_ready(DM_ready), .DM_rdata(DM_rdata),
    .DM_req(DM_req), .DM_we(DM_we), .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_be(DM_be),
    .M_Stall(M_Stall), .M_MemtoReg(M_MemtoReg), .M_RegWrite(M_RegWrite), .M_Jal(M_Jal),
    .M_PC(M_PC), .M_ALU_result(M_ALU_result), .M_WR_out(M_WR_out), .M_MemData(M_MemData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;   // {MemtoReg, RegWrite, Jal}
    logic [17:0] pc;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] mdata;
    int          stalls;
    int          reqs;
  } exp_res_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } exp_req_t;

  exp_res_t    res_q[$];
  exp_req_t    req_q[$];
  int          lat_q[$];
  logic [31:0] dat_q[$];
  logic        spurious;

  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_ex(input logic memto, regw, jal, memw, elh, esh,
                        input logic [17:0] pc, input logic [31:0] alu, rt, input logic [4:0] wr);
    EX_MemtoReg = memto; EX_RegWrite = regw; EX_Jal = jal; EX_MemWrite = memw;
    EX_ExtendLH = elh; EX_ExtendSH = esh;
    EX_PC = pc; EX_ALU_result = alu; EX_Rt_data = rt; EX_WR_out = wr;
  endtask

  task automatic wait_unstalled();
    int guard;
    guard = 0;
    while (M_Stall && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("issue_timeout", 64'(M_Stall), 64'(0));
  endtask

  // Called 1 time unit after a rising edge; returns after the instruction is captured.
  task automatic issue(input logic memto, regw, jal, memw, elh, esh,
                       input logic [17:0] pc, input logic [31:0] alu, rt, input logic [4:0] wr,
                       input logic [31:0] exp_mdata, input int exp_stalls, exp_reqs,
                       input int lat, input logic [31:0] rdata,
                       input logic [15:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata);
    exp_res_t er;
    exp_req_t rq;
    wait_unstalled();
    set_ex(memto, regw, jal, memw, elh, esh, pc, alu, rt, wr);
    er.ctrl = {memto, regw, jal}; er.pc = pc; er.alu = alu; er.wr = wr;
    er.mdata = exp_mdata; er.stalls = exp_stalls; er.reqs = exp_reqs;
    res_q.push_back(er);
    if (memto || memw) begin
      rq.we = memw; rq.addr = exp_addr; rq.be = exp_be; rq.wdata = exp_wdata; rq.chk_wdata = memw;
      req_q.push_back(rq);
      lat_q.push_back(lat);
      dat_q.push_back(rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic bubble();
    wait_unstalled();
    set_ex(0, 0, 0, 0, 0, 0, 18'h0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
  endtask

  // Cache model: answers each new request after the programmed number of wait cycles.
  initial begin
    int          cnt;
    int          cur_lat;
    bit          active;
    logic [31:0] cur_dat;
    DM_ready = 1'b0; DM_rdata = 32'h0;
    cnt = 0; cur_lat = 0; active = 0; cur_dat = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!DM_req) begin
        active   = 0;
        DM_ready = spurious;
        DM_rdata = spurious ? 32'h5555_AAAA : 32'h0;
      end else begin
        if (!active) begin
          active = 1;
          cnt    = 0;
          if (lat_q.size() > 0) begin
            cur_lat = lat_q.pop_front();
            cur_dat = dat_q.pop_front();
          end else begin
            cur_lat = 1000;
            cur_dat = 32'h0;
          end
        end else begin
          cnt++;
        end
        DM_ready = (cnt == cur_lat);
        DM_rdata = DM_ready ? cur_dat : 32'h0BAD_0BAD;
      end
    end
  end

  // Monitor: request checks on every requesting cycle, result checks when M advances.
  initial begin
    exp_res_t er;
    exp_req_t rq;
    int       stall_cnt;
    int       req_cnt;
    bit       prev_done;
    stall_cnt = 0; req_cnt = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0; req_cnt = 0; prev_done = 0;
      end else begin
        if (prev_done) check("req_after_done", 64'(DM_req), 64'(0));
        prev_done = DM_req && DM_ready;
        if (DM_req) begin
          if (req_q.size() == 0) begin
            check("unexpected_req", 64'(DM_req), 64'(0));
          end else begin
            rq = req_q[0];
            check("dm_we", 64'(DM_we), 64'(rq.we));
            check("dm_addr", 64'(DM_addr), 64'(rq.addr));
            check("dm_be", 64'(DM_be), 64'(rq.be));
            if (rq.chk_wdata) check("dm_wdata", 64'(DM_wdata), 64'(rq.wdata));
            if (DM_ready) void'(req_q.pop_front());
          end
        end
        if (M_PC != 18'h0) begin
          if (M_Stall) stall_cnt++;
          if (DM_req) req_cnt++;
          if (!M_Stall) begin
            if (res_q.size() == 0) begin
              check("unexpected_commit", 64'(M_PC), 64'(0));
            end else begin
              er = res_q.pop_front();
              check("m_ctrl", 64'({M_MemtoReg, M_RegWrite, M_Jal}), 64'(er.ctrl));
              check("m_pc", 64'(M_PC), 64'(er.pc));
              check("m_alu_result", 64'(M_ALU_result), 64'(er.alu));
              check("m_wr_out", 64'(M_WR_out), 64'(er.wr));
              check("m_memdata", 64'(M_MemData), 64'(er.mdata));
              check("stall_cycles", 64'(stall_cnt), 64'(er.stalls));
              check("req_cycles", 64'(req_cnt), 64'(er.reqs));
            end
            stall_cnt = 0;
            req_cnt   = 0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0; spurious = 1'b0;
    rst = 1'b1;
    // Nonzero ALU op sits on EX during reset and must be captured on the first free edge.
    set_ex(0, 1, 0, 0, 0, 0, 18'h100, 32'h0000_1234, 32'hFFFF_FFFF, 5'd5);
    @(posedge clk); @(posedge clk); #1;
    check("rst_dm_req", 64'(DM_req), 64'(0));
    check("rst_dm_we", 64'(DM_we), 64'(0));
    check("rst_dm_be", 64'(DM_be), 64'(0));
    check("rst_m_stall", 64'(M_Stall), 64'(0));
    check("rst_m_ctrl", 64'({M_MemtoReg, M_RegWrite, M_Jal}), 64'(0));
    check("rst_m_pc", 64'(M_PC), 64'(0));
    check("rst_m_alu", 64'(M_ALU_result), 64'(0));
    check("rst_m_wr", 64'(M_WR_out), 64'(0));
    check("rst_m_memdata", 64'(M_MemData), 64'(0));
    begin
      exp_res_t er;
      er.ctrl = 3'b010; er.pc = 18'h100; er.alu = 32'h0000_1234; er.wr = 5'd5;
      er.mdata = 32'h0; er.stalls = 0; er.reqs = 0;
      res_q.push_back(er);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Jal ALU op with stray DM_ready pulses outside any access.
    spurious = 1'b1;
    issue(0, 1, 1, 0, 0, 0, 18'h104, 32'hFFFF_0000, 32'h0, 5'd31, 32'h0, 0, 0,
          0, 32'h0, 16'h0, 4'h0, 32'h0);
    spurious = 1'b0;
    // Word load, ready at once.
    issue(1, 1, 0, 0, 0, 0, 18'h108, 32'h0000_0040, 32'h1111_1111, 5'd7, 32'hDEAD_BEEF, 2, 1,
          0, 32'hDEAD_BEEF, 16'h0010, 4'b1111, 32'h0);
    // Halfword load of the upper half with 3 wait cycles.
    issue(1, 1, 0, 0, 1, 0, 18'h10C, 32'h0000_0042, 32'h0, 5'd8, 32'hFFFF_8001, 5, 4,
          3, 32'h8001_0000, 16'h0010, 4'b1111, 32'h0);
    // Halfword store upper, then a back-to-back word store with one wait cycle.
    issue(0, 0, 0, 1, 0, 1, 18'h110, 32'h0000_0042, 32'h0000_ABCD, 5'd0, 32'hFFFF_8001, 2, 1,
          0, 32'h0, 16'h0010, 4'b1100, 32'hABCD_ABCD);
    issue(0, 0, 0, 1, 0, 0, 18'h114, 32'h0000_0080, 32'hCAFE_F00D, 5'd0, 32'hFFFF_8001, 3, 2,
          1, 32'h0, 16'h0020, 4'b1111, 32'hCAFE_F00D);
    // Halfword load of the lower half, odd address, positive value.
    issue(1, 1, 0, 0, 1, 0, 18'h118, 32'h1000_0041, 32'h0, 5'd9, 32'h0000_7FFE, 2, 1,
          0, 32'h1234_7FFE, 16'h0010, 4'b1111, 32'h0);
    // Halfword store lower with 2 wait cycles.
    issue(0, 0, 0, 1, 0, 1, 18'h11C, 32'h0000_0044, 32'h1234_5678, 5'd0, 32'h0000_7FFE, 4, 3,
          2, 32'h0, 16'h0011, 4'b0011, 32'h5678_5678);
    // ALU op after memory ops leaves the load data alone.
    issue(0, 1, 0, 0, 0, 0, 18'h120, 32'h0000_0007, 32'h0, 5'd3, 32'h0000_7FFE, 0, 0,
          0, 32'h0, 16'h0, 4'h0, 32'h0);
    bubble();
    for (int i = 0; i < 60 && res_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_results", 64'(res_q.size()), 64'(0));
    check("drain_requests", 64'(req_q.size()), 64'(0));

    // Load whose cache never answers, abandoned by reset.
    issue(1, 1, 0, 0, 0, 0, 18'h124, 32'h0000_0050, 32'h0, 5'd4, 32'h0, 0, 0,
          1000, 32'h0, 16'h0014, 4'b1111, 32'h0);
    set_ex(0, 0, 0, 0, 0, 0, 18'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 10 && !DM_req; i++) begin
      @(posedge clk); #1;
    end
    check("mid_access_req", 64'(DM_req), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_dm_req", 64'(DM_req), 64'(0));
    check("abort_dm_we", 64'(DM_we), 64'(0));
    check("abort_dm_be", 64'(DM_be), 64'(0));
    check("abort_m_stall", 64'(M_Stall), 64'(0));
    check("abort_m_ctrl", 64'({M_MemtoReg, M_RegWrite, M_Jal}), 64'(0));
    check("abort_m_pc", 64'(M_PC), 64'(0));
    check("abort_m_alu", 64'(M_ALU_result), 64'(0));
    check("abort_m_memdata", 64'(M_MemData), 64'(0));
    rst = 1'b0;
    res_q.delete(); req_q.delete(); lat_q.delete(); dat_q.delete();
    @(posedge clk); #1;
    check("post_abort_req", 64'(DM_req), 64'(0));
    check("post_abort_stall", 64'(M_Stall), 64'(0));

    // Pipeline runs normally after the abort.
    issue(0, 1, 0, 0, 0, 0, 18'h128, 32'h0000_00A5, 32'h0, 5'd2, 32'h0, 0, 0,
          0, 32'h0, 16'h0, 4'h0, 32'h0);
    bubble();
    for (int i = 0; i < 20 && res_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("final_drain", 64'(res_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
EX→MEM pipeline register combined with the data-memory access controller. It captures the EX-stage results and the WB/M control bits. For loads and stores it runs a request/ready handshake with the data cache and holds the pipeline with M_Stall until the access completes. It formats halfword store data and byte enables, and extends halfword load data. Outputs feed the MEM/WB register.

Parameters:
pc_size, 18, PC width carried for Jal link
data_size, 32, datapath width
addr_size, 16, data-cache word-address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
EX_MemtoReg  in  1  load instruction / WB selects memory data
EX_RegWrite  in  1  WB register write enable
EX_MemWrite  in  1  store instruction
EX_Jal  in  1  link write of PC
EX_ExtendLH  in  1  load is halfword, sign-extended
EX_ExtendSH  in  1  store is halfword
EX_PC  in  pc_size  instruction PC
EX_ALU_result  in  data_size  ALU output / byte address
EX_Rt_data  in  data_size  forwarded store data
EX_WR_out  in  5  destination register
DM_ready  in  1  cache has completed the current request
DM_rdata  in  data_size  cache read word, valid with DM_ready
DM_req  out  1  cache request
DM_we  out  1  1 = write, 0 = read
DM_addr  out  addr_size  word address = M_ALU_result[addr_size+1:2]
DM_wdata  out  data_size  store data
DM_be  out  4  byte enables
M_Stall  out  1  freeze PC, IF_ID, ID_EX and this register
M_MemtoReg, M_RegWrite, M_Jal  out  1 each  registered controls to WB
M_PC  out  pc_size  registered PC
M_ALU_result  out  data_size  registered ALU result
M_WR_out  out  5  registered destination
M_MemData  out  data_size  formatted load data

Behaviour:
- rst (sync): all M_* registers = 0, M_MemData = 0, state = IDLE. DM_req, DM_we, DM_be, M_Stall = 0. rst wins over every other condition. A reset during ACCESS abandons the request; DM_req drops on the next cycle.
- Pipeline register: when !M_Stall, M_* <= EX_* at the edge. When M_Stall, M_* hold. ExtendLH, ExtendSH and MemWrite are held internally as M-stage copies.
- mem_op = M_MemtoReg | M_MemWrite.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if mem_op, then M_Stall = 1 and next = ACCESS. Otherwise M_Stall = 0.
  - ACCESS: DM_req = 1, M_Stall = 1. On DM_ready, next = DONE; for a load, M_MemData <= formatted DM_rdata. Without DM_ready, remain in ACCESS indefinitely.
  - DONE: DM_req = 0, M_Stall = 0. The pipeline advances; next = IDLE.
- M_Stall is combinational from state and mem_op: (IDLE & mem_op) | ACCESS.
- Latency: a memory op stalls at least 2 cycles (IDLE and ACCESS with immediate ready), then releases in DONE. Each extra cycle without DM_ready adds 1 stall cycle. Non-memory ops take 0 stall cycles.
- Back-to-back memory ops: after DONE the next op enters in IDLE and is re-evaluated. There is no double issue for the same instruction.
- DM_ready outside ACCESS is ignored.
- Drive rules while DM_req = 1 (DM_addr, DM_we and the store formatting are stable for the whole request):
  - DM_we = M_MemWrite.
  - Word store: DM_be = 1111, DM_wdata = Rt.
  - Halfword store: DM_wdata = {Rt[15:0], Rt[15:0]}; DM_be = 0011 if addr bit1 = 0, 1100 if addr bit1 = 1.
  - Load: DM_be = 1111.
- Load formatting:
  - Word: M_MemData = DM_rdata.
  - ExtendLH: select half by ALU_result[1] (0 selects [15:0], 1 selects [31:16]), then sign-extend to data_size.
- M_MemData holds its value until the next completed load and is unchanged by non-load instructions. Address bit0 is ignored; there is no misalignment trap.

Test Plan:
- Reset: rst = 1 for 2 cycles with EX inputs nonzero → all outputs 0, DM_req = 0. Deassert rst → the next edge captures EX_*.
- ALU op: RegWrite = 1, ALU_result = 0x1234, WR = 5 → M_ALU_result = 0x1234 and M_WR_out = 5 one cycle later; M_Stall never asserts.
- Word load, ready on the first ACCESS cycle, ALU_result = 0x40, DM_rdata = 0xDEADBEEF:
  - M_Stall = 1 for 2 cycles; DM_req = 1 for 1 cycle.
  - DM_addr = 0x10, DM_be = 1111.
  - M_MemData = 0xDEADBEEF in DONE.
- Halfword load with 3 wait cycles, ALU_result = 0x42, DM_rdata = 0x8001_0000:
  - DM_req held for 4 cycles; M_Stall = 1 for 5 cycles.
  - M_MemData = 0xFFFF8001.
- Halfword store at 0x42, Rt = 0x0000ABCD → DM_we = 1, DM_be = 1100, DM_wdata = 0xABCDABCD. Follow it with a back-to-back word store → second request issued only after DONE/IDLE.
- Reset mid-ACCESS (ready never asserted) → next cycle state = IDLE, DM_req = 0, M_Stall = 0, M_* = 0.
